// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle CPU sequencing controller: fetch/decode/execute/memory/writeback
// FSM with a memory-ack timeout, sticky error flags and a retired-instruction
// counter.
module cpu_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        mem_ack,
  output logic [2:0]  state,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        mem_ifetch,
  output logic        mtr_sel,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic        mem_err,
  output logic [15:0] instr_count
);

  localparam int unsigned CW_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned CW     = (CW_RAW < 4) ? 4 : CW_RAW;
  localparam logic [CW-1:0] TMO  = CW'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI, C_SYS
  } cls_t;

  state_t        state_q, state_d;
  cls_t          cls_q, dec_cls;
  logic          dec_legal;
  logic [CW-1:0] tmo_q, tmo_d, tmo_inc;
  logic          tmo_hit;
  logic          set_ill, set_merr;
  logic          illegal_q, mem_err_q;
  logic [15:0]   cnt_q;
  logic          br_taken;

  // Classify the opcode presented while in DECODE
  always_comb begin
    dec_cls   = C_R;
    dec_legal = 1'b1;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: begin
        dec_cls   = C_BRANCH;
        dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
      end
      7'b1101111: dec_cls = C_JAL;
      7'b0110111: dec_cls = C_LUI;
      7'b1110011: dec_cls = C_SYS;
      default:    dec_legal = 1'b0;
    endcase
  end

  assign br_taken = ((funct3 == 3'b000) &&  zero) ||
                    ((funct3 == 3'b001) && !zero);
  assign tmo_inc  = tmo_q + CW'(1);
  assign tmo_hit  = (tmo_inc == TMO);

  // Next-state selection; an ack in the final timeout cycle takes priority
  always_comb begin
    state_d  = state_q;
    set_ill  = 1'b0;
    set_merr = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d  = S_HALT;
          set_merr = 1'b1;
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          state_d = S_HALT;
          set_ill = 1'b1;
        end else if (dec_cls == C_SYS) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH:        state_d = S_FETCH;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
        end else if (tmo_hit) begin
          state_d  = S_HALT;
          set_merr = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Timeout counter: any state change clears it, which covers every entry
  // into FETCH or MEM; it only counts while waiting in those two states.
  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if ((state_q == S_FETCH) || (state_q == S_MEM)) begin
      tmo_d = tmo_inc;
    end
  end

  // Control strobes decoded from the current state and latched class
  always_comb begin
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    rf_we      = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_ifetch = 1'b0;
    mtr_sel    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        mem_ifetch = 1'b1;
        ir_we      = mem_ack;
      end
      S_EXEC: begin
        alu_src = cls_q inside {C_I, C_LOAD, C_STORE, C_LUI};
        if ((cls_q == C_R) || (cls_q == C_I)) begin
          alu_op = funct3;
        end else if (cls_q == C_BRANCH) begin
          alu_op = 3'b001;
        end
        if (cls_q == C_BRANCH) begin
          pc_we  = 1'b1;
          pc_src = br_taken ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_wr  = (cls_q == C_STORE);
        pc_we   = mem_ack && (cls_q == C_STORE);
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        mtr_sel = (cls_q == C_LOAD);
        pc_src  = (cls_q == C_JAL) ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  // State, class latch, timeout, sticky flags and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cls_q     <= C_R;
      tmo_q     <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (state_q == S_DECODE) cls_q <= dec_cls;
      if (set_ill)  illegal_q <= 1'b1;
      if (set_merr) mem_err_q <= 1'b1;
      if (pc_we && (cnt_q != '1)) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign state       = state_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);
  assign illegal     = illegal_q;
  assign mem_err     = mem_err_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl. Each instruction is expanded from the
// spec's per-class rules into an expected cycle-by-cycle trace, then replayed.
module tb_cpu_seq_ctrl;

  localparam int unsigned TMO = 15;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst, start, zero, mem_ack;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [2:0]  state;
  logic        ir_we, pc_we, rf_we, alu_src, mem_req, mem_wr, mem_ifetch, mtr_sel;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;
  logic        busy, halted, illegal, mem_err;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3),
    .zero(zero), .mem_ack(mem_ack), .state(state), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .alu_src(alu_src),
    .alu_op(alu_op), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_ifetch(mem_ifetch), .mtr_sel(mtr_sel), .busy(busy),
    .halted(halted), .illegal(illegal), .mem_err(mem_err),
    .instr_count(instr_count)
  );

  typedef struct packed {
    logic        start;
    logic        ack;
    logic        zr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [2:0]  st;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        rf_we;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        mem_req;
    logic        mem_wr;
    logic        mem_ifetch;
    logic        mtr_sel;
    logic [15:0] cnt;
    logic        ill;
    logic        merr;
  } cyc_t;

  cyc_t        tr[$];
  logic [15:0] m_cnt;
  logic        m_ill, m_merr;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  // Spec class table: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 LUI, 7 SYS, -1 illegal
  function automatic int cls_of(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_R:   return 0;
      OP_I:   return 1;
      OP_LD:  return 2;
      OP_ST:  return 3;
      OP_BR:  return (f3 == 3'b000 || f3 == 3'b001) ? 4 : -1;
      OP_JAL: return 5;
      OP_LUI: return 6;
      OP_SYS: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic cyc_t blank(input logic [2:0] st, input logic [6:0] op,
                                 input logic [2:0] f3);
    cyc_t c;
    c       = '0;
    c.st    = st;
    c.op    = op;
    c.f3    = f3;
    c.zr    = 1'($urandom_range(0, 1));
    c.ack   = 1'($urandom_range(0, 1));
    c.start = (st == 3'd0) ? 1'b0 : 1'($urandom_range(0, 1));
    return c;
  endfunction

  function automatic void push(input cyc_t c_in);
    cyc_t c;
    c      = c_in;
    c.cnt  = m_cnt;
    c.ill  = m_ill;
    c.merr = m_merr;
    tr.push_back(c);
    if (c.pc_we && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endfunction

  function automatic void add_start();
    cyc_t c;
    c       = blank(3'd0, OP_I, 3'd0);
    c.start = 1'b1;
    push(c);
  endfunction

  function automatic void add_fetch_wait();
    cyc_t c;
    c            = blank(3'd1, OP_I, 3'd0);
    c.ack        = 1'b0;
    c.mem_req    = 1'b1;
    c.mem_ifetch = 1'b1;
    push(c);
  endfunction

  function automatic void add_halt(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push(blank(3'd6, OP_I, 3'($urandom)));
  endfunction

  // fl/ml: cycle (1-based) in which ack arrives; 0 means it never arrives.
  // Returns 1 when the instruction ends the run in HALT.
  function automatic bit add_instr(input logic [6:0] op, input logic [2:0] f3,
                                   input int unsigned fl, input int unsigned ml,
                                   input logic zr);
    cyc_t c;
    int k;
    int unsigned nf, nm;
    k  = cls_of(op, f3);
    nf = (fl == 0) ? TMO : fl;
    for (int unsigned i = 1; i <= nf; i++) begin
      c            = blank(3'd1, op, f3);
      c.mem_req    = 1'b1;
      c.mem_ifetch = 1'b1;
      c.ack        = (fl != 0) && (i == fl);
      c.ir_we      = c.ack;
      push(c);
    end
    if (fl == 0) begin m_merr = 1'b1; return 1'b1; end
    push(blank(3'd2, op, f3));
    if (k < 0) begin m_ill = 1'b1; return 1'b1; end
    if (k == 7) return 1'b1;
    c         = blank(3'd3, op, f3);
    c.alu_src = (k == 1 || k == 2 || k == 3 || k == 6);
    c.alu_op  = (k <= 1) ? f3 : ((k == 4) ? 3'b001 : 3'b000);
    if (k == 4) begin
      c.zr     = zr;
      c.pc_we  = 1'b1;
      c.pc_src = ((f3 == 3'b000 && zr) || (f3 == 3'b001 && !zr)) ? 2'b01 : 2'b00;
      push(c);
      return 1'b0;
    end
    push(c);
    if (k == 2 || k == 3) begin
      nm = (ml == 0) ? TMO : ml;
      for (int unsigned j = 1; j <= nm; j++) begin
        c         = blank(3'd4, op, f3);
        c.mem_req = 1'b1;
        c.mem_wr  = (k == 3);
        c.ack     = (ml != 0) && (j == ml);
        c.pc_we   = c.ack && (k == 3);
        push(c);
      end
      if (ml == 0) begin m_merr = 1'b1; return 1'b1; end
      if (k == 3) return 1'b0;
    end
    c         = blank(3'd5, op, f3);
    c.rf_we   = 1'b1;
    c.pc_we   = 1'b1;
    c.mtr_sel = (k == 2);
    c.pc_src  = (k == 5) ? 2'b10 : 2'b00;
    push(c);
    return 1'b0;
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    start   = 1'($urandom_range(0, 1));
    mem_ack = 1'($urandom_range(0, 1));
    zero    = 1'b0;
    opcode  = OP_I;
    funct3  = 3'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst    = 1'b0;
    start  = 1'b0;
    m_cnt  = 16'd0;
    m_ill  = 1'b0;
    m_merr = 1'b0;
    tr.delete();
  endtask

  // Drive each expected cycle and compare outputs before the next edge
  task automatic play_trace(input string tag);
    cyc_t c;
    logic [15:0] got, want;
    while (tr.size() > 0) begin
      c       = tr.pop_front();
      start   = c.start;
      mem_ack = c.ack;
      zero    = c.zr;
      opcode  = c.op;
      funct3  = c.f3;
      #4;
      got  = {state, ir_we, pc_we, pc_src, rf_we, alu_src, alu_op,
              mem_req, mem_wr, mem_ifetch, mtr_sel};
      want = {c.st, c.ir_we, c.pc_we, c.pc_src, c.rf_we, c.alu_src, c.alu_op,
              c.mem_req, c.mem_wr, c.mem_ifetch, c.mtr_sel};
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s st/strobes: got %b want %b (t=%0t)", tag, got, want, $time);
      end
      n_cmp++;
      if (instr_count !== c.cnt) begin
        n_fail++;
        $display("FAIL %s instr_count: got %0d want %0d (t=%0t)", tag, instr_count, c.cnt, $time);
      end
      n_cmp++;
      if ({busy, halted, illegal, mem_err} !==
          {(c.st != 3'd0 && c.st != 3'd6), (c.st == 3'd6), c.ill, c.merr}) begin
        n_fail++;
        $display("FAIL %s busy/halted/illegal/mem_err: got %b want %b (t=%0t)", tag,
                 {busy, halted, illegal, mem_err},
                 {(c.st != 3'd0 && c.st != 3'd6), (c.st == 3'd6), c.ill, c.merr}, $time);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bit h;
    do_reset();
    add_start();
    h = add_instr(OP_I, 3'd2, 1, 0, 1'b0);
    h = add_instr(OP_BAD, 3'd0, 2, 0, 1'b0);
    add_halt(2);
    play_trace("pre_reset");
    // reset from HALT with start/ack also high: reset must win
    rst = 1'b1; start = 1'b1; mem_ack = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({state, busy, halted, illegal, mem_err, instr_count} !== {3'd0, 4'b0000, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_regs: got st=%0d b/h/i/m=%b cnt=%0d want st=0 0000 cnt=0",
               state, {busy, halted, illegal, mem_err}, instr_count);
    end
    n_cmp++;
    if ({ir_we, pc_we, pc_src, rf_we, alu_src, alu_op, mem_req, mem_wr, mem_ifetch, mtr_sel} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 0",
               {ir_we, pc_we, pc_src, rf_we, alu_src, alu_op, mem_req, mem_wr, mem_ifetch, mtr_sel});
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n_cmp++;
      if (state !== 3'd0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold: got st=%0d mem_req=%b want st=0 mem_req=0", state, mem_req);
      end
    end
  endtask

  task automatic test_addi();
    bit h;
    do_reset();
    add_start();
    h = add_instr(OP_I, 3'($urandom), 2, 0, 1'b0);
    add_fetch_wait();
    play_trace("addi");
  endtask

  task automatic test_branch();
    bit h;
    do_reset();
    add_start();
    h = add_instr(OP_BR, 3'b000, 1, 0, 1'b1);
    h = add_instr(OP_BR, 3'b000, 1, 0, 1'b0);
    h = add_instr(OP_BR, 3'b001, 1, 0, 1'b0);
    h = add_instr(OP_BR, 3'b001, 1, 0, 1'b1);
    add_fetch_wait();
    play_trace("branch");
  endtask

  task automatic test_load_store();
    bit h;
    do_reset();
    add_start();
    h = add_instr(OP_LD, 3'd2, 1, 3, 1'b0);
    h = add_instr(OP_ST, 3'd2, 3, 1, 1'b0);
    h = add_instr(OP_LD, 3'd0, TMO, TMO, 1'b0);
    h = add_instr(OP_JAL, 3'd5, 1, 0, 1'b0);
    h = add_instr(OP_LUI, 3'd7, 1, 0, 1'b0);
    h = add_instr(OP_R, 3'd4, 1, 0, 1'b0);
    add_fetch_wait();
    play_trace("ld_st");
  endtask

  task automatic test_fetch_timeout();
    bit h;
    do_reset();
    add_start();
    h = add_instr(OP_I, 3'd0, 0, 0, 1'b0);
    add_halt(5);
    play_trace("fetch_tmo");
  endtask

  task automatic test_mem_timeout();
    bit h;
    do_reset();
    add_start();
    h = add_instr(OP_ST, 3'd0, 1, 0, 1'b0);
    add_halt(4);
    play_trace("mem_tmo");
  endtask

  task automatic test_illegal();
    bit h;
    do_reset();
    add_start();
    h = add_instr(OP_BAD, 3'd0, 1, 0, 1'b0);
    add_halt(3);
    play_trace("illegal_op");
    do_reset();
    add_start();
    h = add_instr(OP_R, 3'd1, 1, 0, 1'b0);
    h = add_instr(OP_BR, 3'b010, 1, 0, 1'b0);
    add_halt(3);
    play_trace("illegal_br");
    do_reset();
    add_start();
    h = add_instr(OP_SYS, 3'd0, 1, 0, 1'b0);
    add_halt(3);
    play_trace("sys");
  endtask

  task automatic test_reset_mid_store();
    bit h;
    do_reset();
    add_start();
    h = add_instr(OP_I, 3'd0, 1, 0, 1'b0);
    h = add_instr(OP_ST, 3'd0, 1, 5, 1'b0);
    for (int i = 0; i < 4; i++) tr.pop_back();
    play_trace("store_pre");
    rst = 1'b1; mem_ack = 1'b0; start = 1'b1;
    #4;
    n_cmp++;
    if (state !== 3'd4 || mem_req !== 1'b1 || instr_count !== 16'd1) begin
      n_fail++;
      $display("FAIL store_mem2: got st=%0d mem_req=%b cnt=%0d want st=4 mem_req=1 cnt=1",
               state, mem_req, instr_count);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; start = 1'b0;
    #4;
    n_cmp++;
    if (state !== 3'd0 || mem_req !== 1'b0 || instr_count !== 16'd0 || pc_we !== 1'b0) begin
      n_fail++;
      $display("FAIL store_rst: got st=%0d mem_req=%b cnt=%0d pc_we=%b want st=0 mem_req=0 cnt=0 pc_we=0",
               state, mem_req, instr_count, pc_we);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_cmp++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL store_after: got st=%0d want 0", state);
    end
  endtask

  task automatic test_random_program();
    logic [6:0] ops [7];
    logic [6:0] op;
    logic [2:0] f3;
    int unsigned fl, ml;
    bit h;
    ops[0] = OP_R;  ops[1] = OP_I;   ops[2] = OP_LD; ops[3] = OP_ST;
    ops[4] = OP_BR; ops[5] = OP_JAL; ops[6] = OP_LUI;
    do_reset();
    add_start();
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 6)];
      f3 = (op == OP_BR) ? 3'($urandom_range(0, 1)) : 3'($urandom);
      fl = ($urandom_range(0, 5) == 0) ? TMO : $urandom_range(1, 4);
      ml = ($urandom_range(0, 5) == 0) ? TMO : $urandom_range(1, 4);
      h  = add_instr(op, f3, fl, ml, 1'($urandom_range(0, 1)));
    end
    h = add_instr(OP_SYS, 3'd0, 1, 0, 1'b0);
    add_halt(3);
    play_trace("random");
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_load_store();
    test_fetch_timeout();
    test_mem_timeout();
    test_illegal();
    test_reset_mid_store();
    test_random_program();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum number of cycles to wait for mem_ack in FETCH or MEM.
REQ-002 Port list (name, direction, width, meaning); clock and reset come first:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution from IDLE.
- opcode  in  7  instruction bits [6:0], from the instruction register.
- funct3  in  3  instruction bits [14:12].
- zero  in  1  ALU zero flag.
- mem_ack  in  1  memory transfer complete.
- state  out  3  current FSM state.
- ir_we  out  1  instruction register write enable.
- pc_we  out  1  PC write enable.
- pc_src  out  2  PC source select.
- rf_we  out  1  register file write enable.
- alu_src  out  1  ALU operand B select: 0 = register, 1 = immediate.
- alu_op  out  3  ALU function.
- mem_req  out  1  memory request.
- mem_wr  out  1  memory write.
- mem_ifetch  out  1  the current request is an instruction fetch.
- mtr_sel  out  1  memory-to-register select.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- illegal  out  1  sticky: illegal instruction detected.
- mem_err  out  1  sticky: memory timeout.
- instr_count  out  16  number of retired instructions.

Function
REQ-003 State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 goes to HALT on the next edge.
REQ-004 IDLE: start=1 goes to FETCH; otherwise stay. start is ignored in every other state.
REQ-005 FETCH: mem_req=1, mem_ifetch=1, mem_wr=0.
- mem_ack=1 in this state: ir_we=1 in the same cycle; next state DECODE.
REQ-006 Class is latched in DECODE from opcode:
- R = 0110011
- I = 0010011
- LOAD = 0000011
- STORE = 0100011
- BRANCH = 1100011
- JAL = 1101111
- LUI = 0110111
- SYS = 1110011
REQ-007 DECODE lasts one cycle. Next state:
- SYS: HALT.
- Unlisted opcode, or BRANCH with funct3 other than 000/001: HALT, with illegal set.
- Otherwise: EXEC.
REQ-008 EXEC lasts one cycle.
- alu_src=1 for I, LOAD, STORE and LUI; 0 otherwise.
- alu_op=funct3 for R and I; 001 (SUB) for BRANCH; 000 (ADD) otherwise.
REQ-009 EXEC next state:
- R, I, LUI, JAL: WB.
- LOAD, STORE: MEM.
- BRANCH: FETCH, with pc_we=1 in EXEC. pc_src=01 when taken, 00 otherwise.
- Taken means funct3=000 with zero=1, or funct3=001 with zero=0.
REQ-010 MEM: mem_req=1, mem_ifetch=0, mem_wr=1 for STORE and 0 for LOAD. On mem_ack:
- STORE: pc_we=1, pc_src=00; next state FETCH.
- LOAD: next state WB.
REQ-011 WB lasts one cycle.
- rf_we=1 and pc_we=1.
- mtr_sel=1 only for LOAD.
- pc_src=10 for JAL, 00 otherwise.
- Next state: FETCH.
REQ-012 Timeout counter (4 bits minimum, sized to MEM_TIMEOUT):
- Cleared on entry to FETCH or MEM; increments each cycle in those states without mem_ack.
- Reaching MEM_TIMEOUT with no ack goes to HALT and sets mem_err.
- An ack in the same cycle as the count reaching MEM_TIMEOUT wins; no error.
REQ-013 mem_ack is ignored whenever mem_req=0.
REQ-014 HALT: all strobes are 0 and halted=1. HALT is left only through rst.
REQ-015 Outputs are decoded from state and the latched class only. Exceptions:
- ir_we, pc_we, pc_src and state exit may also use mem_ack and zero combinationally.
- All other outputs in every state not listed above are 0.
REQ-016 instr_count increments on every cycle with pc_we=1 and saturates at 0xFFFF.
REQ-017 illegal and mem_err stay set until rst.

Reset
REQ-018 rst=1 at a rising edge sets state=IDLE, instr_count=0, illegal=0, mem_err=0, timeout counter=0 and latched class=R.
REQ-019 Outputs after reset: every strobe 0, busy=0, halted=0.
REQ-020 rst has priority over start, mem_ack and every pending transition.
REQ-021 rst mid-transfer: mem_req is low in the cycle after the reset edge, and the controller does not wait for an outstanding ack.

Verification
REQ-022 ADDI flow: start pulse, ack in the 2nd FETCH cycle, opcode=0010011 -> states 1,1,2,3,5,1; rf_we and pc_we high only in WB; instr_count=1.
REQ-023 BEQ taken: opcode=1100011, funct3=000, zero=1 -> EXEC shows alu_op=001, pc_src=01, pc_we=1; next state FETCH; no WB.
REQ-024 LOAD with ack after 3 MEM cycles -> mem_req high for 3 cycles, mem_wr=0, then WB with mtr_sel=1 and rf_we=1.
REQ-025 Memory timeout: mem_ack held 0 in FETCH -> HALT after 15 cycles, mem_err=1, halted=1; later start and mem_ack are ignored.
REQ-026 Illegal opcode 1111111 -> DECODE then HALT, illegal=1, instr_count unchanged.
REQ-027 Reset mid-STORE: rst asserted in the 2nd MEM cycle -> next cycle state=0, mem_req=0, instr_count=0.
